// File: rtl/puf_challenge_sequencer.sv
// PUF challenge sequencer.
// Walks an 8-bit challenge through an external scrambler and applies each scrambled
// challenge to an arbiter PUF. It waits a fixed settle time, then samples one response
// bit per challenge and packs the bits MSB-first into bytes. Each byte is handed to a
// serial TX using a valid/ready handshake. Every control strobe is a registered output.
module puf_challenge_sequencer #(
    parameter int SETTLE_CYCLES = 16,
    parameter int NUM_BYTES     = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] seed,
    output logic [7:0] seed_out,
    output logic       scr_increment,
    input  logic [7:0] scr_chall,
    output logic [7:0] puf_chall,
    output logic       puf_trigger,
    input  logic       puf_resp,
    output logic [7:0] resp_byte,
    output logic       resp_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       done
);

    // Settle counter reload value: counting down to zero gives SETTLE_CYCLES cycles in SETTLE.
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] BYTES_LAST  = 8'(NUM_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_APPLY,
        S_SETTLE,
        S_SAMPLE,
        S_SEND,
        S_DONE
    } state_t;

    state_t      state_q;
    logic [7:0]  seed_q;
    logic [7:0]  chall_q;
    logic [7:0]  resp_byte_q;
    logic        resp_valid_q;
    logic        scr_inc_q;
    logic        trig_q;
    logic        done_q;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  byte_cnt_q;
    logic [7:0]  settle_q;
    logic [6:0]  shift_q;

    logic [2:0]  bit_cnt_d;
    logic [7:0]  byte_cnt_d;
    logic [7:0]  settle_d;
    logic [7:0]  shift_d;
    logic        handshake;

    // Incremented counters and the shift value with the new response bit appended.
    always_comb begin
        bit_cnt_d  = bit_cnt_q + 3'd1;
        byte_cnt_d = byte_cnt_q + 8'd1;
        settle_d   = settle_q - 8'd1;
        shift_d    = {shift_q, puf_resp};
        handshake  = resp_valid_q & tx_ready;
    end

    // Sequencer FSM. The single-cycle strobes default low and are raised on the edge entering their cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            seed_q       <= 8'h00;
            chall_q      <= 8'h00;
            resp_byte_q  <= 8'h00;
            resp_valid_q <= 1'b0;
            scr_inc_q    <= 1'b0;
            trig_q       <= 1'b0;
            done_q       <= 1'b0;
            bit_cnt_q    <= 3'd0;
            byte_cnt_q   <= 8'd0;
            settle_q     <= 8'd0;
            shift_q      <= 7'd0;
        end else begin
            scr_inc_q <= 1'b0;
            trig_q    <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        seed_q     <= seed;
                        bit_cnt_q  <= 3'd0;
                        byte_cnt_q <= 8'd0;
                        scr_inc_q  <= 1'b1;
                        state_q    <= S_LOAD;
                    end
                end
                // The scrambler advances at the end of this cycle, so its new output is stable during APPLY.
                S_LOAD: begin
                    state_q <= S_APPLY;
                end
                S_APPLY: begin
                    chall_q  <= scr_chall;
                    trig_q   <= 1'b1;
                    settle_q <= SETTLE_LOAD;
                    state_q  <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_q == 8'd0) begin
                        state_q <= S_SAMPLE;
                    end else begin
                        settle_q <= settle_d;
                    end
                end
                S_SAMPLE: begin
                    shift_q   <= shift_d[6:0];
                    bit_cnt_q <= bit_cnt_d;
                    if (bit_cnt_q == 3'd7) begin
                        resp_byte_q  <= shift_d;
                        resp_valid_q <= 1'b1;
                        state_q      <= S_SEND;
                    end else begin
                        scr_inc_q <= 1'b1;
                        state_q   <= S_LOAD;
                    end
                end
                // The byte is held until the TX accepts it. The scrambler keeps its state across bytes.
                S_SEND: begin
                    if (handshake) begin
                        resp_valid_q <= 1'b0;
                        byte_cnt_q   <= byte_cnt_d;
                        if (byte_cnt_d == BYTES_LAST) begin
                            state_q <= S_DONE;
                        end else begin
                            scr_inc_q <= 1'b1;
                            state_q   <= S_LOAD;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign seed_out      = seed_q;
    assign scr_increment = scr_inc_q;
    assign puf_chall     = chall_q;
    assign puf_trigger   = trig_q;
    assign resp_byte     = resp_byte_q;
    assign resp_valid    = resp_valid_q;
    assign done          = done_q;
    assign busy          = (state_q != S_IDLE);

endmodule

// File: doc/puf_challenge_sequencer.md
PUF_CHALLENGE_SEQUENCER -- requirements
Module: puf_challenge_sequencer

Parameters
REQ-001 SHALL have parameter SETTLE_CYCLES, default 16: cycles waited after the challenge is applied before the PUF response is sampled (range 1..255).
REQ-002 SHALL have parameter NUM_BYTES, default 4: response bytes produced per run (range 1..255).

Interface
REQ-003 SHALL have port clock, input, 1: single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: level-sampled run request; accepted only in IDLE.
REQ-006 SHALL have port seed, input, 8: initial challenge, captured when start is accepted.
REQ-007 SHALL have port seed_out, output, 8: captured seed, driven to the scrambler challenge input.
REQ-008 SHALL have port scr_increment, output, 1: one-cycle advance strobe to the scrambler.
REQ-009 SHALL have port scr_chall, input, 8: scrambled challenge returned by the scrambler.
REQ-010 SHALL have port puf_chall, output, 8: challenge applied to the PUF delay lines.
REQ-011 SHALL have port puf_trigger, output, 1: one-cycle launch pulse to the PUF.
REQ-012 SHALL have port puf_resp, input, 1: arbiter output, already synchronised to clock.
REQ-013 SHALL have port resp_byte, output, 8: assembled response byte.
REQ-014 SHALL have port resp_valid, output, 1: resp_byte is valid.
REQ-015 SHALL have port tx_ready, input, 1: downstream serial TX accepts the byte.
REQ-016 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-017 SHALL have port done, output, 1: one-cycle pulse at the end of a run.

Function
REQ-018 SHALL implement the FSM IDLE -> LOAD -> APPLY -> SETTLE -> SAMPLE -> (LOAD | SEND) -> (LOAD | DONE) -> IDLE.
REQ-019 IDLE: when start=1, SHALL capture seed into seed_out, clear the bit and byte counters, and go to LOAD; start in any other state SHALL be ignored.
REQ-020 LOAD: SHALL assert scr_increment for exactly 1 cycle, then go to APPLY.
REQ-021 APPLY: SHALL register puf_chall <= scr_chall, assert puf_trigger for exactly 1 cycle, load the settle counter with SETTLE_CYCLES-1, and go to SETTLE.
REQ-022 SETTLE: SHALL decrement the settle counter each cycle and go to SAMPLE in the cycle after it reaches 0, giving exactly SETTLE_CYCLES cycles.
REQ-023 SAMPLE: SHALL shift MSB-first (shift <= {shift[6:0], puf_resp}) and increment the 3-bit bit counter; on bit counter 7 -> 0 wrap SHALL go to SEND, otherwise to LOAD.
REQ-024 Bit period SHALL be SETTLE_CYCLES+3 cycles; resp_valid SHALL first rise 8*(SETTLE_CYCLES+3) cycles after the edge that accepts start.
REQ-025 SEND: SHALL hold resp_valid=1 with resp_byte stable until the first cycle in which tx_ready=1 and resp_valid=1 (the handshake).
REQ-026 resp_valid SHALL drop in the cycle after the handshake; tx_ready=1 while resp_valid=0 SHALL have no effect.
REQ-027 After the handshake the byte counter SHALL increment; if it equals NUM_BYTES the FSM SHALL go to DONE, otherwise to LOAD. The scrambler state SHALL continue across bytes and SHALL NOT be reseeded.
REQ-028 DONE: SHALL assert done for 1 cycle and return to IDLE; seed_out, puf_chall and resp_byte SHALL hold their last values.
REQ-029 scr_increment, puf_trigger, done and resp_valid SHALL all be registered outputs.

Reset
REQ-030 Reset asserted at any time, including mid-run or mid-handshake, SHALL immediately force IDLE and clear all counters.
REQ-031 During reset SHALL drive seed_out=0x00, puf_chall=0x00, resp_byte=0x00, resp_valid=0, scr_increment=0, puf_trigger=0, busy=0, done=0.
REQ-032 After reset is released, the first start SHALL be honoured on the first rising edge.

Verification
REQ-033 SETTLE_CYCLES=4, NUM_BYTES=1, puf_resp held at 1, tx_ready=1 -> resp_byte=0xFF, resp_valid rises 56 cycles after the start edge, done pulses 2 cycles later.
REQ-034 puf_resp follows the pattern 1,0,1,0,0,1,0,1 on successive SAMPLE cycles -> resp_byte=0xA5.
REQ-035 tx_ready held at 0 for 20 cycles in SEND -> resp_valid and resp_byte stay stable for all 20 cycles; the handshake completes on the cycle tx_ready rises; no extra scr_increment is issued.
REQ-036 NUM_BYTES=4 -> exactly 32 scr_increment pulses, 32 puf_trigger pulses, 4 handshakes and 1 done pulse.
REQ-037 Reset asserted during SETTLE of bit 5 -> all outputs take reset values asynchronously; a new start after release produces a full, correct run.
REQ-038 start pulsed while busy=1 -> no effect on counters, seed_out, or the total pulse counts.
